// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the neopixel pattern sources.
package neopixel_pkg;

  // Colour-wheel segment: which two channels are cross-fading.
  typedef enum logic [1:0] {
    PH_RG = 2'd0,
    PH_GB = 2'd1,
    PH_BR = 2'd2
  } phase_e;

  localparam int unsigned CHAN_MAX = 255;

  // Position on the 765-level wheel; level stays within 0..254.
  typedef struct packed {
    phase_e     phase;
    logic [7:0] level;
  } hue_t;

  // WS2812 wire order is green, red, blue.
  function automatic logic [23:0] pack_grb(input logic [7:0] red, input logic [7:0] green,
                                           input logic [7:0] blue);
    return {green, red, blue};
  endfunction

endpackage

// File: rtl/hue_wheel.sv
// Combinational hue stepper and hue-to-GRB converter.
module hue_wheel
  import neopixel_pkg::*;
#(
  parameter int unsigned Step = 5
) (
  input  hue_t        hue,
  output hue_t        hue_next,
  output logic [23:0] color,
  output logic [23:0] color_next
);

  function automatic logic [23:0] hue_to_grb(input hue_t h);
    logic [7:0] inv;
    inv = 8'(CHAN_MAX) - h.level;
    case (h.phase)
      PH_RG:   return pack_grb(inv, h.level, 8'd0);
      PH_GB:   return pack_grb(8'd0, inv, h.level);
      PH_BR:   return pack_grb(h.level, 8'd0, inv);
      default: return 24'd0;
    endcase
  endfunction

  function automatic phase_e phase_inc(input phase_e p);
    case (p)
      PH_RG:   return PH_GB;
      PH_GB:   return PH_BR;
      default: return PH_RG;
    endcase
  endfunction

  logic [8:0] sum;

  // Step never exceeds 254, so at most one segment boundary is crossed.
  always_comb begin
    sum = {1'b0, hue.level} + 9'(Step);
    hue_next = hue;
    if (sum >= 9'(CHAN_MAX)) begin
      hue_next.level = 8'(sum - 9'(CHAN_MAX));
      hue_next.phase = phase_inc(hue.phase);
    end else begin
      hue_next.level = sum[7:0];
    end
  end

  assign color      = hue_to_grb(hue);
  assign color_next = hue_to_grb(hue_next);

endmodule

// File: rtl/rainbow_frame_gen.sv
// Scrolling-rainbow frame producer with a valid/ready pixel stream.
module rainbow_frame_gen
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 150,
  parameter int unsigned PIXEL_STEP = 5,
  parameter int unsigned FRAME_STEP = 15,
  parameter int unsigned FRAME_DIV  = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pix_addr,
  output logic [23:0] pix_color,
  output logic        frame_done,
  output logic        frame_overrun
);

  localparam int unsigned      DivW     = $clog2(FRAME_DIV);
  localparam logic [DivW-1:0]  DivLast  = DivW'(FRAME_DIV - 1);
  localparam logic [15:0]      AddrLast = 16'(NUM_LEDS - 1);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  hue_t             start_hue_q, start_hue_d;
  hue_t             pix_hue_q, pix_hue_d;
  logic             pix_valid_q, pix_valid_d;
  logic [15:0]      pix_addr_q, pix_addr_d;
  logic [23:0]      pix_color_q, pix_color_d;
  logic             tick, consume;

  hue_t             pix_hue_next, start_hue_next;
  logic [23:0]      pix_color_next, start_color;
  logic [23:0]      unused_pix_color, unused_start_color_next;

  hue_wheel #(.Step(PIXEL_STEP)) u_pix_wheel (
    .hue        (pix_hue_q),
    .hue_next   (pix_hue_next),
    .color      (unused_pix_color),
    .color_next (pix_color_next)
  );

  hue_wheel #(.Step(FRAME_STEP)) u_start_wheel (
    .hue        (start_hue_q),
    .hue_next   (start_hue_next),
    .color      (start_color),
    .color_next (unused_start_color_next)
  );

  // Frame-tick divider; held at zero while disabled.
  always_comb begin
    tick  = enable && (div_q == DivLast);
    div_d = div_q + 1'b1;
    if (!enable || tick) div_d = '0;
  end

  // Pixel FSM: load a frame, stream NUM_LEDS pixels, then advance the start hue.
  always_comb begin
    state_d     = state_q;
    pix_valid_d = pix_valid_q;
    pix_addr_d  = pix_addr_q;
    pix_color_d = pix_color_q;
    pix_hue_d   = pix_hue_q;
    start_hue_d = start_hue_q;
    consume     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          consume     = 1'b1;
          pix_hue_d   = start_hue_q;
          pix_addr_d  = '0;
          pix_color_d = start_color;
          pix_valid_d = 1'b1;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (pix_valid_q && pix_ready) begin
          if (pix_addr_q == AddrLast) begin
            pix_valid_d = 1'b0;
            state_d     = StDone;
          end else begin
            pix_addr_d  = pix_addr_q + 16'd1;
            pix_hue_d   = pix_hue_next;
            pix_color_d = pix_color_next;
          end
        end
      end
      StDone: begin
        start_hue_d = start_hue_next;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A tick landing on an already-pending request is dropped and flagged.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (consume) pending_d = 1'b0;
    if (tick) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      start_hue_q <= '{phase: PH_RG, level: 8'd0};
      pix_hue_q   <= '{phase: PH_RG, level: 8'd0};
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      start_hue_q <= start_hue_d;
      pix_hue_q   <= pix_hue_d;
      pix_valid_q <= pix_valid_d;
      pix_addr_q  <= pix_addr_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_addr      = pix_addr_q;
  assign pix_color     = pix_color_q;
  assign frame_done    = (state_q == StDone);
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_rainbow_frame_gen.sv
// Directed bench: DUT A (PIXEL_STEP=5) and DUT B (PIXEL_STEP=100), both 4 LEDs, FRAME_DIV=16.
module tb_rainbow_frame_gen;

  localparam int unsigned Div = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_rdy, a_valid, a_done, a_ovr;
  logic [15:0] a_addr;
  logic [23:0] a_color;
  logic        b_rst, b_en, b_rdy, b_valid, b_done, b_ovr;
  logic [15:0] b_addr;
  logic [23:0] b_color;

  rainbow_frame_gen #(
    .NUM_LEDS(4), .PIXEL_STEP(5), .FRAME_STEP(15), .FRAME_DIV(Div)
  ) u_dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .pix_ready(a_rdy), .pix_valid(a_valid),
    .pix_addr(a_addr), .pix_color(a_color), .frame_done(a_done), .frame_overrun(a_ovr)
  );

  rainbow_frame_gen #(
    .NUM_LEDS(4), .PIXEL_STEP(100), .FRAME_STEP(15), .FRAME_DIV(Div)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .pix_ready(b_rdy), .pix_valid(b_valid),
    .pix_addr(b_addr), .pix_color(b_color), .frame_done(b_done), .frame_overrun(b_ovr)
  );

  int n_vec = 0;
  int n_err = 0;
  int a_done_cnt = 0;

  always @(posedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [23:0] color;
    bit          last;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wheel position 0..764 to GRB, straight from the segment definitions.
  function automatic logic [23:0] model_color(input int pos);
    int p, l;
    logic [7:0] lv, inv;
    p   = pos % 765;
    l   = p % 255;
    lv  = 8'(l);
    inv = 8'(255 - l);
    case (p / 255)
      0:       return {lv, inv, 8'h00};
      1:       return {inv, 8'h00, lv};
      default: return {8'h00, lv, inv};
    endcase
  endfunction

  // Returns the next accepted pixel; leaves the caller on the negedge after the accept.
  task automatic wait_accept(input int sel, output bit ok, output logic [15:0] addr,
                             output logic [23:0] color);
    ok = 1'b0;
    addr = '0;
    color = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (sel == 0 ? (a_valid && a_rdy) : (b_valid && b_rdy)) begin
        addr  = (sel == 0) ? a_addr : b_addr;
        color = (sel == 0) ? a_color : b_color;
        ok    = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit          ok, seen;
    logic [15:0] addr;
    logic [23:0] color;
    int          n, d0;

    vecs[0]  = '{0, 16'd0, 24'h00FF00, 1'b0};
    vecs[1]  = '{0, 16'd1, 24'h05FA00, 1'b0};
    vecs[2]  = '{0, 16'd2, 24'h0AF500, 1'b0};
    vecs[3]  = '{0, 16'd3, 24'h0FF000, 1'b1};
    vecs[4]  = '{0, 16'd0, 24'h0FF000, 1'b0};
    vecs[5]  = '{0, 16'd1, 24'h14EB00, 1'b0};
    vecs[6]  = '{0, 16'd2, 24'h19E600, 1'b0};
    vecs[7]  = '{0, 16'd3, 24'h1EE100, 1'b1};
    vecs[8]  = '{1, 16'd0, 24'h00FF00, 1'b0};
    vecs[9]  = '{1, 16'd1, 24'h649B00, 1'b0};
    vecs[10] = '{1, 16'd2, 24'hC83700, 1'b0};
    vecs[11] = '{1, 16'd3, 24'hD2002D, 1'b1};

    a_rst = 1'b1; b_rst = 1'b1;
    a_en = 1'b0; b_en = 1'b0;
    a_rdy = 1'b0; b_rdy = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    check("reset valid", 32'(a_valid), 32'd0);
    check("reset addr", 32'(a_addr), 32'd0);
    check("reset color", 32'(a_color), 32'd0);
    check("reset done", 32'(a_done), 32'd0);
    check("reset overrun", 32'(a_ovr), 32'd0);

    a_en = 1'b1; b_en = 1'b1;
    a_rdy = 1'b1;

    // Table: two frames of A, then B's first frame (B has been stalled meanwhile).
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].sel == 1) b_rdy = 1'b1;
      wait_accept(vecs[v].sel, ok, addr, color);
      check($sformatf("vec%0d accept", v), 32'(ok), 32'd1);
      check($sformatf("vec%0d addr", v), 32'(addr), 32'(vecs[v].addr));
      check($sformatf("vec%0d color", v), 32'(color), 32'(vecs[v].color));
      if (vecs[v].last) begin
        check($sformatf("vec%0d done pulse", v), 32'(vecs[v].sel == 0 ? a_done : b_done), 32'd1);
        @(negedge clk);
        check($sformatf("vec%0d done low", v), 32'(vecs[v].sel == 0 ? a_done : b_done), 32'd0);
      end
    end

    // B: 51 more frames; start hue walks 15 levels per frame and returns to 0.
    for (int k = 1; k <= 51; k++) begin
      for (int i = 0; i < 4; i++) begin
        wait_accept(1, ok, addr, color);
        check($sformatf("wheel f%0d p%0d accept", k, i), 32'(ok), 32'd1);
        check($sformatf("wheel f%0d p%0d addr", k, i), 32'(addr), i);
        check($sformatf("wheel f%0d p%0d color", k, i), 32'(color),
              32'(model_color(15 * k + 100 * i)));
      end
    end
    check("wheel wrap start", 32'(color), 32'(model_color(300)));

    // Reset A while addr 2 is on the bus.
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_valid && a_addr == 16'd2) ok = 1'b1;
    end
    check("rst wait addr2", 32'(ok), 32'd1);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_rdy = 1'b0;
    check("rst valid", 32'(a_valid), 32'd0);
    check("rst addr", 32'(a_addr), 32'd0);
    check("rst color", 32'(a_color), 32'd0);

    // Backpressure on the first frame after reset.
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_valid) ok = 1'b1;
    end
    check("bp wait valid", 32'(ok), 32'd1);
    check("bp first addr", 32'(a_addr), 32'd0);
    check("bp first color", 32'(a_color), 32'h00FF00);
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("bp hold%0d valid", j), 32'(a_valid), 32'd1);
      check($sformatf("bp hold%0d addr", j), 32'(a_addr), 32'd1);
      check($sformatf("bp hold%0d color", j), 32'(a_color), 32'h05FA00);
      @(negedge clk);
    end
    a_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_accept(0, ok, addr, color);
      check($sformatf("bp p%0d accept", i), 32'(ok), 32'd1);
      check($sformatf("bp p%0d addr", i), 32'(addr), i);
      check($sformatf("bp p%0d color", i), 32'(color), 32'(model_color(5 * i)));
    end

    // Drop enable just after the next frame starts; it must still complete.
    wait_accept(0, ok, addr, color);
    a_en = 1'b0;
    check("en-low p0 accept", 32'(ok), 32'd1);
    check("en-low p0 color", 32'(color), 32'h0FF000);
    for (int i = 1; i < 4; i++) begin
      wait_accept(0, ok, addr, color);
      check($sformatf("en-low p%0d addr", i), 32'(addr), i);
    end
    check("en-low done", 32'(a_done), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3 * Div + 4; i++) begin
      @(negedge clk);
      if (a_valid) seen = 1'b1;
    end
    check("en-low quiet", 32'(seen), 32'd0);

    // Re-enable: first tick after Div cycles, valid one cycle later.
    a_rdy = 1'b0;
    a_en = 1'b1;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (a_valid) ok = 1'b1;
    end
    check("re-enable latency", n, Div + 1);

    // Stall long enough for one pending tick plus one dropped tick.
    repeat (40) @(negedge clk);
    check("ovr hold valid", 32'(a_valid), 32'd1);
    check("ovr hold addr", 32'(a_addr), 32'd0);
    check("ovr flag", 32'(a_ovr), 32'd1);
    a_en = 1'b0;
    a_rdy = 1'b1;
    d0 = a_done_cnt;
    repeat (100) @(negedge clk);
    check("ovr frames after release", a_done_cnt - d0, 2);
    check("ovr sticky", 32'(a_ovr), 32'd1);
    check("ovr idle valid", 32'(a_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
